// File: rtl/multicycle_adder.sv
// Sequential WIDTH-bit adder, CHUNK bits per cycle, start/busy/done handshake.
// Define MULTICYCLE_ADDER_OVF_EN to add the signed-overflow output ovf.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef MULTICYCLE_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic [CHUNK:0]   rc;

  assign ca    = a_q[int'(cnt)*CHUNK +: CHUNK];
  assign cb    = b_q[int'(cnt)*CHUNK +: CHUNK];
  assign rc[0] = carry;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a (ca[i]),
      .b (cb[i]),
      .ci(rc[i]),
      .s (cs[i]),
      .co(rc[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[int'(cnt)*CHUNK +: CHUNK] <= cs;
          carry <= rc[CHUNK];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            cout  <= rc[CHUNK];
`ifdef MULTICYCLE_ADDER_OVF_EN
            // top chunk's MSB is the final sum sign
            ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (cs[CHUNK-1] != a_q[WIDTH-1]);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder: 16/4 scoreboard plus an 8/8 instance.
// Expected results come from a bench-side a+b+cin model.
module tb_multicycle_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout;
  logic [15:0] sum;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
`ifdef MULTICYCLE_ADDER_OVF_EN
  logic        ovf, ovf8;
`endif

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   ndone = 0;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
`ifdef MULTICYCLE_ADDER_OVF_EN
    .ovf  (ovf),
`endif
    .cout (cout)
  );

  multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .cin  (1'b0),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
`ifdef MULTICYCLE_ADDER_OVF_EN
    .ovf  (ovf8),
`endif
    .cout (cout8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      ndone++;
      chk("done_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
`ifdef MULTICYCLE_ADDER_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.v));
`endif
      end
    end
  endtask

  task automatic go(input logic [15:0] x, input logic [15:0] y,
                    input logic c);
    exp_t e;
    logic [16:0] r;
    r   = 17'(x) + 17'(y) + 17'(c);
    e.s = r[15:0];
    e.c = r[16];
    e.v = (x[15] == y[15]) && (r[15] != x[15]);
    q.push_back(e);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    int n;
    d0 = ndone;
    n  = 0;
    while (ndone == d0 && n < 40) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'(ndone != d0), 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int d0;
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    tick();

    // exact latency and busy window
    go(16'h1234, 16'h4321, 1'b0);
    chk("busy_e0", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
    end
    d0 = ndone;
    tick();
    chk("done_at_e4", 32'(ndone - d0), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    tick();
    chk("done_pulse", 32'(done), 32'd0);

    go(16'hFFFF, 16'h0001, 1'b0);
    wait_done();
    tick();
    go(16'hFFFF, 16'h0000, 1'b1);
    wait_done();
    tick();

    // start during RUN is ignored
    go(16'h00FF, 16'h0001, 1'b0);
    tick();
    a = 16'hAAAA;
    b = 16'h5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    d0 = ndone;
    wait_done();
    repeat (6) tick();
    chk("one_done", 32'(ndone - d0), 32'd1);
    chk("sum_held", 32'(sum), 32'h0100);

    // back-to-back start in DONE
    go(16'h0001, 16'h0002, 1'b0);
    wait_done();
    go(16'h8000, 16'h8000, 1'b0);
    chk("b2b_done_drop", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done();
    tick();

`ifdef MULTICYCLE_ADDER_OVF_EN
    go(16'h7FFF, 16'h0001, 1'b0);
    wait_done();
    go(16'hFFFF, 16'h0001, 1'b0);
    wait_done();
`endif

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      go(ra, rb, 1'($urandom_range(1)));
      wait_done();
    end
    tick();

    // reset mid-RUN discards the sum
    go(16'h1234, 16'h1111, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    d0 = ndone;
    repeat (8) tick();
    chk("no_done_after_rst", 32'(ndone - d0), 32'd0);

    // single-chunk instance, latency 1
    a8 = 8'hFF;
    b8 = 8'h01;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("w8_busy", 32'(busy8), 32'd1);
    tick();
    chk("w8_done", 32'(done8), 32'd1);
    chk("w8_sum", 32'(sum8), 32'h00);
    chk("w8_cout", 32'(cout8), 32'd1);
`ifdef MULTICYCLE_ADDER_OVF_EN
    chk("w8_ovf", 32'(ovf8), 32'd0);
`endif
    a8 = 8'h7F;
    b8 = 8'h01;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    chk("w8_done2", 32'(done8), 32'd1);
    chk("w8_sum2", 32'(sum8), 32'h80);
    chk("w8_cout2", 32'(cout8), 32'd0);
`ifdef MULTICYCLE_ADDER_OVF_EN
    chk("w8_ovf2", 32'(ovf8), 32'd1);
`endif
    tick();
    chk("w8_pulse", 32'(done8), 32'd0);

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
